uart_rx_rtl: RTL and testbench



---
 rtl/uart_rx_rtl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_rtl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_rtl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_rtl
// Serial UART receiver: 1 start bit, N data bits (LSB first), optional even
// parity bit, 1 stop bit. Each correctly framed word is delivered on o_data
// with a single-cycle o_dv pulse. Baud timing is derived from CLK_FREQ/BR, so
// it pairs directly with a transmitter built from the same parameters.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected after the last data bit and
//   the o_parity_err port is present.
//
// Ports:
//   i_clk        in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   rx           in   serial line (asynchronous, idle high)
//   o_data       out  [N] last correctly framed word
//   o_dv         out  1-cycle pulse, o_data updated this cycle
//   o_frame_err  out  1-cycle pulse, stop bit sampled low, frame dropped
//   o_parity_err out  1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//   rx_busy      out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_rtl #(
  parameter int N        = 8,
  parameter int BR       = 9600,
  parameter int CLK_FREQ = 50000000
) (
  input  logic         i_clk,
  input  logic         rst_n,
  input  logic         rx,
  output logic [N-1:0] o_data,
  output logic         o_dv,
  output logic         o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic         o_parity_err,
`endif
  output logic         rx_busy
);

  localparam int CLK_PER_B = CLK_FREQ / BR;
  localparam int HALF_B    = CLK_PER_B / 2;
  localparam int CW        = (CLK_PER_B > 2) ? $clog2(CLK_PER_B) : 1;
  localparam int IW        = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_B - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_B - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA_BITS, PARITY, STOP, CLEANUP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA_BITS, STOP, CLEANUP
  } state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  data_q;
  logic          dv_q;
  logic          ferr_q;
  logic          rx_s1_q;  // first synchroniser stage
  logic          rx_s_q;   // synchronised line, the only copy used for sampling
  logic          rx_d_q;   // one cycle older copy, for falling-edge detection
`ifdef UART_RX_PARITY_EN
  logic          par_q;
  logic          perr_q;
`endif

  // Next shift value: new bit enters at the MSB so that after N samples the
  // first-received bit sits at bit 0. Written this way so N==1 also works.
  logic [N-1:0] shift_d;
  assign shift_d = (shift_q >> 1) | (N'(rx_s_q) << (N - 1));

  // Synchroniser and edge-detect flops; they reset high to match idle line.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s_q  <= rx_s1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      // Status outputs are single-cycle pulses.
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Only a high-to-low transition arms the receiver; a held-low
          // line (break) never produces a new start.
          if (!rx_s_q && rx_d_q) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            // Still low at mid-start: genuine start bit. Otherwise a glitch.
            state_q <= rx_s_q ? IDLE : DATA_BITS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA_BITS: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= CLEANUP;
            if (rx_s_q) begin
              data_q <= shift_q;
              dv_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              perr_q <= ^{shift_q, par_q};
`endif
            end else begin
              // Frame error wins: word discarded, no parity report.
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // One cycle while the pulse set above is visible. Entered at
        // mid-stop-bit, so the next start edge is never missed.
        CLEANUP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_dv        = dv_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_rtl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_rtl
// Directed bench for uart_rx_rtl at CLK_FREQ=1 MHz, BR=100 kbit/s (10 clocks
// per bit), N=8. Expected receive events are queued when a frame is driven;
// a monitor records every output pulse and the stimulus sequence compares the
// two queues after each step.
// -----------------------------------------------------------------------------
module tb_uart_rx_rtl;

  localparam int N        = 8;
  localparam int BR       = 100000;
  localparam int CLK_FREQ = 1000000;
  localparam int CPB      = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CYC = 11 * CPB;
`else
  localparam int FRAME_CYC = 10 * CPB;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx    = 1'b1;
  logic [N-1:0] o_data;
  logic         o_dv;
  logic         o_frame_err;
  logic         rx_busy;
`ifdef UART_RX_PARITY_EN
  logic         o_parity_err;
`endif

  uart_rx_rtl #(.N(N), .BR(BR), .CLK_FREQ(CLK_FREQ)) dut (
    .i_clk       (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .o_data      (o_data),
    .o_dv        (o_dv),
    .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         dv;
    logic         ferr;
    logic         perr;
    logic [N-1:0] data;
    int unsigned  t;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int errors = 0;
  int checks = 0;

  // Record every cycle in which any status pulse is high.
  always @(negedge clk) begin
    ev_t e;
    e.dv   = o_dv;
    e.ferr = o_frame_err;
`ifdef UART_RX_PARITY_EN
    e.perr = o_parity_err;
`else
    e.perr = 1'b0;
`endif
    e.data = o_data;
    e.t    = cyc;
    if (e.dv !== 1'b0 || e.ferr !== 1'b0 || e.perr !== 1'b0) obs_q.push_back(e);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ok(input logic [N-1:0] d, input logic perr);
    ev_t e;
    e.dv = 1'b1; e.ferr = 1'b0; e.perr = perr; e.data = d; e.t = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [N-1:0] prev);
    ev_t e;
    e.dv = 1'b0; e.ferr = 1'b1; e.perr = 1'b0; e.data = prev; e.t = 0;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < N; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;  // parity bit not on the wire in this build
`endif
    send_bit(stop);
  endtask

  // Wait (bounded) for the queued events, then compare pairwise.
  task automatic drain(input string tag);
    int n;
    ev_t o;
    ev_t e;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".dv"},   o.dv,   e.dv);
      chk({tag, ".ferr"}, o.ferr, e.ferr);
      chk({tag, ".perr"}, o.perr, e.perr);
      chk({tag, ".data"}, o.data, e.data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, t1;
    int n;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.data", o_data, 8'h00);
    chk("rst.dv", o_dv, 1'b0);
    chk("rst.ferr", o_frame_err, 1'b0);
    chk("rst.busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    obs_q.delete();

    // 1: plain frame
    push_ok(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    drain("t1");
    chk("t1.busy", rx_busy, 1'b0);
    $display("t1 frame 0xA5 done, o_data=0x%0h", o_data);

    // 2: short glitch, then a real frame
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t2.busy", rx_busy, 1'b0);
    drain("t2.glitch");
    push_ok(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    drain("t2");
    $display("t2 glitch + frame 0x3C done, o_data=0x%0h", o_data);

    // 3: stop bit low, line held low (break)
    push_err(8'h3C);
    send_frame(8'h77, 1'b0, ^8'h77);
    repeat (50) @(negedge clk);
    chk("t3.busy_break", rx_busy, 1'b0);
    drain("t3");
    chk("t3.data_kept", o_data, 8'h3C);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    drain("t3.after");
    $display("t3 framing error + break done, o_data=0x%0h", o_data);

    // 4: back-to-back frames, zero idle gap
    push_ok(8'h00, 1'b0);
    push_ok(8'hFF, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    n = 0;
    while (obs_q.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    t0 = 0;
    t1 = 0;
    if (obs_q.size() >= 2) begin
      t0 = obs_q[0].t;
      t1 = obs_q[1].t;
    end
    chk("t4.spacing", t1 - t0, FRAME_CYC);
    drain("t4");
    $display("t4 back-to-back 0x00/0xFF done, spacing=%0d", t1 - t0);

    // 5: reset during the 4th data bit of 0x5A
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h5A >> i));
    rx = 1'(8'h5A >> 3);
    repeat (5) @(negedge clk);
    chk("t5.busy_before", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_data", o_data, 8'h00);
    chk("t5.rst_dv", o_dv, 1'b0);
    chk("t5.rst_ferr", o_frame_err, 1'b0);
    chk("t5.rst_busy", rx_busy, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drain("t5.partial");
    push_ok(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    drain("t5");
    $display("t5 reset mid-frame + frame 0x5A done, o_data=0x%0h", o_data);

`ifdef UART_RX_PARITY_EN
    // 6: parity error reported alongside o_dv, then clean parity
    push_ok(8'h01, 1'b1);
    send_frame(8'h01, 1'b1, 1'b0);
    drain("t6.bad");
    push_ok(8'h01, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    drain("t6.good");
    $display("t6 parity frames done, o_data=0x%0h", o_data);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
